somador_serial_nibble: RTL and testbench

Nibble-serial adder/sequencer that computes a 4·N_NIBBLES-bit sum by time-multiplexing one 4-bit ripple adder over N_NIBBLES clock cycles. It latches wide operands through a valid/ready input handshake. It steps the nibble index and propagates carry between cycles in a register, then presents the result through a valid/ready output handshake. It is the area-minimal wide adder for the Problema datapaths, trading latency for a single adder instance.

---
 rtl/somador_pkg.sv | 18 +
 rtl/somador_serial_nibble_quatrobitsadder.sv | 27 ++
 rtl/somador_serial_nibble.sv | 141 ++++++++++++++
 tb/tb_somador_serial_nibble.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// nibble width and the index-width helper.
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // A one-nibble build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/somador_serial_nibble_quatrobitsadder.sv
// quatrobitsadder: plain 4-bit ripple-carry adder, the single arithmetic
// element shared across all nibbles of the serial adder.
module quatrobitsadder
  import somador_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  // Carries kept as separate nets so the ripple chain is not a self-loop on one vector.
  logic c1;
  logic c2;
  logic c3;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign c2   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign s[2] = a[2] ^ b[2] ^ c2;
  assign c3   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
  assign s[3] = a[3] ^ b[3] ^ c3;
  assign cout = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/somador_serial_nibble.sv
// Nibble-serial wide adder: one quatrobitsadder reused over N_NIBBLES cycles.
// Define SOMADOR_SUB_EN to honour the sub input (a - b); otherwise sub is ignored.
module somador_serial_nibble
  import somador_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] a,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] b,
  input  logic                          cin,
  input  logic                          sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*N_NIBBLES-1:0] s,
  output logic                          cout,
  output logic                          ovf,
  output logic [1:0]                    state_dbg
);

  localparam int W     = NIBBLE_W * N_NIBBLES;
  localparam int IDX_W = idx_width(N_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  if (N_NIBBLES < 1 || N_NIBBLES > 16) begin : g_bad_param
    $error("somador_serial_nibble: N_NIBBLES must be in 1..16");
  end

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]                       idx_q;
  logic                                   carry_q;
  logic [N_NIBBLES-1:0][NIBBLE_W-1:0]     a_q;
  logic [N_NIBBLES-1:0][NIBBLE_W-1:0]     bx_q;
  logic [N_NIBBLES-1:0][NIBBLE_W-1:0]     s_q;
  logic                                   cout_q;
  logic                                   ovf_q;

  logic                                   accept;
  logic                                   step;
  logic                                   last;
  logic [W-1:0]                           b_eff;
  logic                                   c_eff;
  logic [NIBBLE_W-1:0]                    nib_s;
  logic                                   nib_c;

  // Subtraction is a + ~b + 1, so only the b path and the initial carry change.
`ifdef SOMADOR_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  quatrobitsadder u_adder (
    .a    (a_q[idx_q]),
    .b    (bx_q[idx_q]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is a pure function of state (never of out_ready); out_valid,
  // once raised, stays high with s/cout/ovf stable until out_ready is seen.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= a;
        bx_q    <= b_eff;
        carry_q <= c_eff;
        idx_q   <= '0;
      end
      if (step) begin
        s_q[idx_q] <= nib_s;
        carry_q    <= nib_c;
        idx_q      <= idx_q + 1'b1;
        // On the top nibble nib_s[3] is the result sign bit.
        if (last) begin
          cout_q <= nib_c;
          ovf_q  <= (a_q[N_NIBBLES-1][NIBBLE_W-1] == bx_q[N_NIBBLES-1][NIBBLE_W-1]) &&
                    (nib_s[NIBBLE_W-1] != a_q[N_NIBBLES-1][NIBBLE_W-1]);
        end
      end
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_somador_serial_nibble.sv
// Bench for somador_serial_nibble: directed vectors plus randomized
// transactions scored against an arithmetic reference model.
module tb_somador_serial_nibble;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W+1:0] exp_q[$];   // {cout, ovf, s}
  logic [W-1:0] res_s;
  logic         res_cout;
  logic         res_ovf;

  somador_serial_nibble #(.N_NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tcin, input logic tsub);
    longint full;
    longint sres;
    longint sa;
    longint sb;
    bit     do_sub;
    logic   m_ovf;
    logic   m_cout;
    logic [W-1:0] m_s;
    do_sub = 1'b0;
`ifdef SOMADOR_SUB_EN
    do_sub = tsub;
`else
    if (tsub) do_sub = 1'b0;
`endif
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    if (do_sub) begin
      full = longint'(ta) - longint'(tb) + (longint'(1) << W);
      sres = sa - sb;
    end else begin
      full = longint'(ta) + longint'(tb) + longint'(tcin);
      sres = sa + sb + longint'(tcin);
    end
    m_s    = full[W-1:0];
    m_cout = full[W];
    m_ovf  = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
    return {m_cout, m_ovf, m_s};
  endfunction

  // ---------------- driver ----------------
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub, input int hold);
    int lat;
    logic [W+1:0] e;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(ta, tb, tcin, tsub));
    @(posedge clk);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'(N));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    res_s = s; res_cout = cout; res_ovf = ovf;
    check("s", s, e[W-1:0]);
    check("cout", cout, e[W+1]);
    check("ovf", ovf, e[W]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_s", s, e[W-1:0]);
      check("hold_cout", cout, e[W+1]);
      check("hold_ovf", ovf, e[W]);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    do_txn(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    check("add_s", res_s, 16'h2233);
    check("add_cout", res_cout, 1'b0);
    check("add_ovf", res_ovf, 1'b0);

    do_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    check("wrap_s", res_s, 16'h0000);
    check("wrap_cout", res_cout, 1'b1);
    check("wrap_ovf", res_ovf, 1'b0);

    do_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    check("povf_s", res_s, 16'h8000);
    check("povf_cout", res_cout, 1'b0);
    check("povf_ovf", res_ovf, 1'b1);

    do_txn(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
`ifdef SOMADOR_SUB_EN
    check("sub1_s", res_s, 16'hFFFE);
    check("sub1_cout", res_cout, 1'b0);
    check("sub1_ovf", res_ovf, 1'b0);
`else
    check("sub1_s", res_s, 16'h000C);
    check("sub1_cout", res_cout, 1'b0);
    check("sub1_ovf", res_ovf, 1'b0);
`endif

    do_txn(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
`ifdef SOMADOR_SUB_EN
    check("sub2_s", res_s, 16'h7FFF);
    check("sub2_cout", res_cout, 1'b1);
    check("sub2_ovf", res_ovf, 1'b1);
`else
    check("sub2_s", res_s, 16'h8001);
    check("sub2_cout", res_cout, 1'b0);
    check("sub2_ovf", res_ovf, 1'b0);
`endif

    // Backpressure: five cycles held in DONE with a competing in_valid.
    do_txn(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 5);

    // Reset mid-RUN at idx = 2.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_s", s, '0);
    check("arst_cout", cout, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    check("after_rst_s", res_s, 16'h0002);

    // Randomized transactions, including edge-heavy operands.
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 6 == 0) ra = 16'hFFFF;
      if (k % 6 == 1) rb = 16'h8000;
      do_txn(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
